// File: rtl/scene_pkg.sv
// Shared types for the scene transition sequencer.
// State codes double as the HEX5 display value.
package scene_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } scene_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [3:0] FADE_MAX = 4'd15;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings raw VGA_VS into the CLK domain as a one-cycle tick.
// Two sync stages, a level history flop and a registered edge.
module frame_tick_sync (
  input  logic CLK,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic s1_q, s2_q, prev_q, tick_q;
  logic tick_d;

  assign tick_d = s2_q & ~prev_q;

  // synchronize VS and register its rising edge
  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= frame_clk;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/scene_sequencer.sv
// Frame-paced fade-out / background swap / fade-in controller.
// Freezes the character while a transition is running.
import scene_pkg::*;

module scene_sequencer #(
  parameter int unsigned NUM_SCENES  = 8,
  parameter int unsigned FADE_FRAMES = 4,
  parameter int unsigned SCENE_W     = 11
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               top_reached,
  input  logic               bot_reached,
  output logic [SCENE_W-1:0] background_number,
  output logic [3:0]         fade_level,
  output logic               char_freeze,
  output logic               scene_changed,
  output logic [3:0]         HEXstate
);

  localparam int unsigned CW = $clog2(FADE_FRAMES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES - 1);
  localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);

  scene_state_t       state_q, state_d;
  dir_t               dir_q, dir_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         fade_q, fade_d;
  logic [SCENE_W-1:0] bg_q, bg_d;
  logic               chg_q, chg_d;
  logic               frz_q;

  logic tick;
  logic step;
  logic top_ok, bot_ok;

  frame_tick_sync u_sync (
    .CLK      (CLK),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .tick     (tick)
  );

  assign step   = tick && (cnt_q == CNT_LAST);
  assign top_ok = top_reached && (bg_q < SCENE_LAST);
  assign bot_ok = bot_reached && (bg_q != '0);

  // next state: request acceptance, fade stepping, scene swap
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    fade_d  = fade_q;
    bg_d    = bg_q;
    chg_d   = 1'b0;
    unique case (state_q)
      PLAY: begin
        fade_d = '0;
        cnt_d  = '0;
        if (tick) begin
          if (top_ok) begin
            dir_d   = DIR_UP;
            state_d = FADE_OUT;
          end else if (bot_ok) begin
            dir_d   = DIR_DOWN;
            state_d = FADE_OUT;
          end
        end
      end
      FADE_OUT: begin
        if (tick) cnt_d = step ? '0 : cnt_q + CW'(1);
        if (step) begin
          if (fade_q == FADE_MAX) state_d = SWAP;
          else fade_d = fade_q + 4'd1;
        end
      end
      SWAP: begin
        bg_d    = (dir_q == DIR_UP) ? bg_q + SCENE_W'(1)
                                    : bg_q - SCENE_W'(1);
        chg_d   = 1'b1;
        cnt_d   = '0;
        state_d = FADE_IN;
      end
      FADE_IN: begin
        if (tick) cnt_d = step ? '0 : cnt_q + CW'(1);
        if (step) begin
          if (fade_q == 4'd0) state_d = PLAY;
          else fade_d = fade_q - 4'd1;
        end
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= PLAY;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      fade_q  <= '0;
      bg_q    <= '0;
      chg_q   <= 1'b0;
      frz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      fade_q  <= fade_d;
      bg_q    <= bg_d;
      chg_q   <= chg_d;
      frz_q   <= (state_d != PLAY);
    end
  end

  assign background_number = bg_q;
  assign fade_level        = fade_q;
  assign scene_changed     = chg_q;
  assign char_freeze       = frz_q;
  assign HEXstate          = {2'b00, state_q};

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer with one step tick per fade level.
// Expected values are hand-derived from the transition timing.
module tb_scene_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_clk;
  logic        top, bot;
  logic [10:0] bg;
  logic [3:0]  fade;
  logic [3:0]  hex;
  logic        frz, chg;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;
  int tick_cnt = 0;
  int last_tick_cyc = 0;
  int chg_cnt = 0;
  int swap_cnt = 0;
  logic [10:0] bg_at_chg = '0;

  always #5 clk = ~clk;

  scene_sequencer #(
    .NUM_SCENES (8),
    .FADE_FRAMES(1),
    .SCENE_W    (11)
  ) dut (
    .CLK              (clk),
    .Reset            (rst),
    .frame_clk        (frame_clk),
    .top_reached      (top),
    .bot_reached      (bot),
    .background_number(bg),
    .fade_level       (fade),
    .char_freeze      (frz),
    .scene_changed    (chg),
    .HEXstate         (hex)
  );

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (dut.tick) begin
      tick_cnt++;
      last_tick_cyc = cyc_n;
    end
    if (chg) begin
      chg_cnt++;
      bg_at_chg = bg;
    end
    if (hex == 4'd2) swap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame_clk = 1'b1;
    cyc(4);
    frame_clk = 1'b0;
    cyc(4);
  endtask

  task automatic pulses(input int n);
    repeat (n) pulse();
  endtask

  task automatic trans(input logic t, input logic b);
    top = t;
    bot = b;
    pulse();
    top = 1'b0;
    bot = 1'b0;
    pulses(32);
  endtask

  initial begin
    int c0, s0;
    rst = 1'b1;
    frame_clk = 1'b0;
    top = 1'b0;
    bot = 1'b0;
    cyc(3);
    chk("rst_bg", bg, 0);
    chk("rst_fade", fade, 0);
    chk("rst_frz", frz, 0);
    chk("rst_chg", chg, 0);
    chk("rst_hex", hex, 0);
    rst = 1'b0;
    cyc(2);

    for (int i = 0; i < 3; i++) begin
      pulse();
      chk("idle_bg", bg, 0);
      chk("idle_fade", fade, 0);
      chk("idle_frz", frz, 0);
    end

    bot = 1'b1;
    pulse();
    bot = 1'b0;
    chk("bot0_hex", hex, 0);
    chk("bot0_frz", frz, 0);

    c0 = chg_cnt;
    s0 = swap_cnt;
    top = 1'b1;
    pulse();
    top = 1'b0;
    chk("acc_hex", hex, 1);
    chk("acc_frz", frz, 1);
    chk("acc_fade", fade, 0);
    for (int k = 1; k <= 15; k++) begin
      pulse();
      chk("out_fade", fade, k);
    end
    chk("out_chg", chg_cnt - c0, 0);
    pulse();
    chk("swp_hex", hex, 3);
    chk("swp_bg", bg, 1);
    chk("swp_fade", fade, 15);
    chk("swp_cnt", swap_cnt - s0, 1);
    chk("chg_cnt", chg_cnt - c0, 1);
    chk("chg_bg", bg_at_chg, 1);
    for (int m = 1; m <= 15; m++) begin
      pulse();
      chk("in_fade", fade, 15 - m);
      chk("in_frz", frz, 1);
    end
    pulse();
    chk("end_hex", hex, 0);
    chk("end_frz", frz, 0);
    chk("end_fade", fade, 0);
    chk("end_bg", bg, 1);

    trans(1'b1, 1'b0);
    trans(1'b1, 1'b0);
    chk("at3_bg", bg, 3);

    c0 = chg_cnt;
    top = 1'b1;
    bot = 1'b1;
    pulse();
    top = 1'b0;
    bot = 1'b0;
    chk("both_hex", hex, 1);
    pulses(16);
    chk("both_in_hex", hex, 3);
    chk("both_bg", bg, 4);
    bot = 1'b1;
    pulse();
    bot = 1'b0;
    chk("drop_hex", hex, 3);
    chk("drop_fade", fade, 14);
    pulses(15);
    chk("drop_end_hex", hex, 0);
    chk("drop_end_frz", frz, 0);
    pulse();
    chk("drop_noq_hex", hex, 0);
    chk("drop_bg", bg, 4);
    chk("drop_chg", chg_cnt - c0, 1);

    repeat (3) trans(1'b1, 1'b0);
    chk("at7_bg", bg, 7);
    top = 1'b1;
    pulse();
    top = 1'b0;
    chk("top7_hex", hex, 0);
    chk("top7_frz", frz, 0);
    chk("top7_bg", bg, 7);
    trans(1'b1, 1'b1);
    chk("both7_bg", bg, 6);
    chk("both7_hex", hex, 0);

    top = 1'b1;
    pulse();
    top = 1'b0;
    pulses(9);
    chk("mid_fade", fade, 9);
    chk("mid_hex", hex, 1);
    rst = 1'b1;
    cyc(1);
    chk("mrst_hex", hex, 0);
    chk("mrst_bg", bg, 0);
    chk("mrst_fade", fade, 0);
    chk("mrst_frz", frz, 0);
    rst = 1'b0;
    cyc(4);

    for (int k = 0; k < 2; k++) begin
      int t0, r0;
      @(posedge clk);
      #(k == 0 ? 3 : 7);
      t0 = tick_cnt;
      frame_clk = 1'b1;
      r0 = cyc_n;
      cyc(6);
      chk("tick_once", tick_cnt - t0, 1);
      chk("tick_lat", last_tick_cyc - r0, 3);
      @(posedge clk);
      #(k == 0 ? 7 : 3);
      frame_clk = 1'b0;
      cyc(6);
      chk("tick_nofall", tick_cnt - t0, 1);
      chk("tick_hex", hex, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
# scene_sequencer

Scene-transition controller between the character/collision logic and `color_mapper`. It watches the top-of-screen and bottom-of-screen reached signals on frame boundaries and sequences a fade-out, background swap and fade-in. While it does so it drives `background_number` and a brightness level to `color_mapper`, and freezes character motion. It replaces the ad-hoc background stepping in `back_controller` with a bounded, frame-paced FSM on the 50 MHz clock.

## Interface
- `NUM_SCENES`, default 8: number of valid backgrounds, indices 0..NUM_SCENES-1.
- `FADE_FRAMES`, default 4: frame ticks per fade step (≥1).
- `SCENE_W`, default 11: width of `background_number`.

- `CLK` in 1: system clock, MAX10_CLK1_50.
- `Reset` in 1: synchronous, active-high.
- `frame_clk` in 1: raw VGA_VS, asynchronous to CLK.
- `top_reached` in 1: character hit top of screen; request next scene.
- `bot_reached` in 1: character hit bottom; request previous scene.
- `background_number` out SCENE_W: current scene to `color_mapper`.
- `fade_level` out 4: 0 = full brightness, 15 = black.
- `char_freeze` out 1: high while a transition is in progress.
- `scene_changed` out 1: one-CLK pulse when `background_number` updates.
- `HEXstate` out 4: state code for HEX5.

## Operation
- Frame tick: `frame_clk` passes through a 2-FF synchronizer, then rising-edge detect. The result is a one-CLK `tick`.
- `top_reached` and `bot_reached` are sampled only on `tick` and only in PLAY.
- Request qualification:
  - top is valid when `background_number < NUM_SCENES-1`.
  - bot is valid when `background_number > 0`.
  - Invalid requests are ignored, with no wrap.
  - If top and bot are both asserted, top wins; if top is invalid, bot is considered.
- Direction (`dir`: up/down) is latched when a request is accepted.
- States (HEXstate code):
  - PLAY (0): `fade_level`=0. A valid request on `tick` → FADE_OUT, and the step counter clears.
  - FADE_OUT (1): step counter counts ticks 0..FADE_FRAMES-1. On the tick where the counter = FADE_FRAMES-1 (a step tick):
    - if `fade_level`=15 → SWAP;
    - else `fade_level`+1.
  - SWAP (2): exactly one CLK. `background_number` ±1 per `dir`, `scene_changed` pulses, → FADE_IN.
  - FADE_IN (3): on a step tick:
    - if `fade_level`=0 → PLAY;
    - else `fade_level`−1.
- `char_freeze` = (state ≠ PLAY), registered.
- Requests arriving outside PLAY are dropped, not queued.
- Arithmetic: `background_number` is unsigned SCENE_W. Bounds checks prevent underflow and overflow. The step counter is $clog2(FADE_FRAMES)+1 bits.

## Timing
- All outputs are registered.
- Reset values: `background_number`=0, `fade_level`=0, `char_freeze`=0, `scene_changed`=0, `HEXstate`=0. State = PLAY, step counter = 0, synchronizer = 0.
- Reset asserted mid-transition returns to PLAY at scene 0 on the next edge.
- `tick` asserts 3 CLKs after the `frame_clk` rising edge: 2 sync stages plus the edge register.
- Request accepted on `tick` at edge N: state=FADE_OUT and `char_freeze`=1 at N+1.
- FADE_OUT duration: 16·FADE_FRAMES ticks. SWAP follows one CLK after the final step tick.
- SWAP → FADE_IN: `background_number` and `scene_changed` update at that same edge; `scene_changed` drops one CLK later.
- FADE_IN duration: 16·FADE_FRAMES ticks. `char_freeze` drops one CLK after the final step tick.
- `fade_level` changes only on step ticks. It is monotonic within FADE_OUT and within FADE_IN.
- A held `top_reached` triggers at most one transition per PLAY visit. After returning to PLAY, a still-valid request is accepted on the next `tick`.

## Structure
- `scene_pkg`:
  - state enum `scene_state_t` {PLAY, FADE_OUT, SWAP, FADE_IN}, with encodings fixed to the HEXstate codes 0..3;
  - `FADE_MAX` = 4'd15;
  - `dir_t` {DIR_UP, DIR_DOWN}.
- Sub-module `frame_tick_sync`: 2-FF synchronizer plus rising-edge detector, taking `frame_clk` to a one-CLK `tick`. It shares the same CLK/Reset.
- Top level `scene_sequencer`: FSM, step counter, scene register, output registers.

## Test plan
- Reset, then 3 `frame_clk` pulses with no requests → `background_number`=0, `fade_level`=0, `char_freeze`=0 throughout.
- FADE_FRAMES=1, `top_reached`=1 on one tick at scene 0:
  - `char_freeze`=1, and `fade_level` climbs 0→15 over 16 ticks;
  - then one SWAP cycle with `scene_changed`=1 and `background_number`=1;
  - `fade_level` falls 15→0 over 16 ticks; `char_freeze`=0 after the last tick.
- At scene 0, `bot_reached`=1 → ignored, state stays PLAY. At scene NUM_SCENES-1=7, `top_reached`=1 → ignored.
- `top_reached` and `bot_reached` asserted together on the same tick at scene 3 → transition to scene 4. `bot_reached` pulsed during FADE_IN → no second transition.
- Reset asserted while `fade_level`=9 in FADE_OUT → next CLK: PLAY, `background_number`=0, `fade_level`=0, `char_freeze`=0.
- `frame_clk` toggled with a misaligned phase relative to CLK → exactly one `tick` per rising edge, observed 3 CLKs later, and no tick on a falling edge.
